// File: rtl/fetch_queue.sv
// Sequential-PC fetch front end: in-order imem responses are buffered with their PCs and handed to decode.
// Fill latency is 2 cycles with 1-cycle memory (1 with FQ_BYPASS_EN); decode stalls hold the head and throttle requests by credit.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [63:0]            imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_instr,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [63:0]            out_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0] sh_rd_q, sh_rd_d;
  logic [SW-1:0] sh_wr_q, sh_wr_d;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [63:0]   pc_mem_q    [DEPTH];
  logic [63:0]   shadow_q    [MAX_OUTST];

  logic          req_fire;
  logic          rsp_any;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          fifo_vld;
  logic          byp_vld;
  logic          push;
  logic          pop;
  int            live;

  function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
    return (int'(p) == MAX_OUTST - 1) ? '0 : p + SW'(1);
  endfunction

  // Live credit excludes responses already condemned by a redirect.
  always_comb begin
    live           = int'(outst_q) - int'(drop_q);
    imem_req_valid = rst && !redirect_valid && (int'(outst_q) < MAX_OUTST)
                     && (int'(count_q) + live < DEPTH);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    rsp_any  = imem_rsp_valid && (outst_q != '0);
    rsp_drop = rsp_any && (redirect_valid || (drop_q != '0));
    rsp_keep = rsp_any && !rsp_drop;
    fifo_vld = (count_q != '0);
`ifdef FQ_BYPASS_EN
    byp_vld  = rsp_keep && !fifo_vld;
`else
    byp_vld  = 1'b0;
`endif

    out_valid = fifo_vld || byp_vld;
    out_instr = 32'h0;
    out_pc    = 64'h0;
    if (fifo_vld) begin
      out_instr = instr_mem_q[rd_ptr_q];
      out_pc    = pc_mem_q[rd_ptr_q];
    end else if (byp_vld) begin
      out_instr = imem_rsp_instr;
      out_pc    = shadow_q[sh_rd_q];
    end

    pop  = fifo_vld && out_ready && !redirect_valid;
    push = rsp_keep && !(byp_vld && out_ready);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rsp_err_d  = rsp_err_q || (imem_rsp_valid && (outst_q == '0));
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    sh_rd_d    = sh_rd_q;
    sh_wr_d    = sh_wr_q;

    if (rsp_any) begin
      outst_d = outst_q - OW'(1);
      sh_rd_d = sh_next(sh_rd_q);
    end

    // Everything still in flight after this edge belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - OW'(1);
      end
      if (req_fire) begin
        outst_d    = outst_d + OW'(1);
        fetch_pc_d = fetch_pc_q + 64'd4;
        sh_wr_d    = sh_next(sh_wr_q);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      rsp_err_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      sh_rd_q    <= '0;
      sh_wr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rsp_err_q  <= rsp_err_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      sh_rd_q    <= sh_rd_d;
      sh_wr_q    <= sh_wr_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_instr;
      pc_mem_q[wr_ptr_q]    <= shadow_q[sh_rd_q];
    end
    if (req_fire) begin
      shadow_q[sh_wr_q] <= fetch_pc_q;
    end
  end

  assign count   = count_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model feeds a scoreboard of expected (pc, instr) pairs.
module tb_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP       = 32'hD503201F;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [63:0]            imem_req_addr;
  logic                   imem_rsp_valid;
  logic [31:0]            imem_rsp_instr;
  logic                   redirect_valid;
  logic [63:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [63:0]            out_pc;
  logic [$clog2(DEPTH):0] count;
  logic                   rsp_err;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [31:0] instr; int due; bit stale; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];    // requests accepted by memory, oldest first
  ent_t        expq[$];    // instructions decode should still see, in order
  logic [63:0] req_log[$];
  logic [63:0] exp_pc;
  ent_t        mon_e;

  int checks = 0, errors = 0, cyc = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100, reqrdy_pct = 100, redir_pct = 0;
  bit nop_mode = 1'b1, force_redir = 1'b0, orphan = 1'b0, err_exp = 1'b0, seen;
  logic [63:0] force_addr = 64'h0;
  int first_req = -1, first_ov = -1, max_cnt = 0, deq_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted output must be the next expected instruction.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready && !redirect_valid) begin
        deq_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h with nothing expected (cycle %0d)", out_pc, cyc);
        end else begin
          mon_e = expq.pop_front();
          chk("out_pc", out_pc, mon_e.pc);
          chk("out_instr", 64'(out_instr), 64'(mon_e.instr));
        end
      end
    end
  end

  task automatic step();
    bit          rsp_now, redir_now, byp, exp_rv, exp_ov;
    int          live;
    logic [63:0] raddr;
    req_t        r;
    @(negedge clk);
    cyc++;
    rsp_now   = (pend.size() > 0) && (pend[0].due <= cyc);
    redir_now = force_redir || (int'($urandom_range(99)) < redir_pct);
    raddr     = force_redir ? force_addr : ({$urandom, $urandom} & ~64'h3);
    imem_rsp_valid = rsp_now || orphan;
    imem_rsp_instr = rsp_now ? pend[0].instr : 32'($urandom);
    redirect_valid = redir_now;
    redirect_pc    = raddr;
    out_ready      = (int'($urandom_range(99)) < rdy_pct);
    imem_req_ready = orphan ? 1'b0 : (int'($urandom_range(99)) < reqrdy_pct);
    #1;
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    chk("count", 64'(count), 64'(expq.size()));
    exp_rv = !redir_now && (pend.size() < MAX_OUTST) && (expq.size() + live < DEPTH);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    byp = 1'b0;
`ifdef FQ_BYPASS_EN
    byp = rsp_now && !pend[0].stale && !redir_now && (expq.size() == 0);
`endif
    exp_ov = (expq.size() != 0) || byp;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (orphan) err_exp = 1'b1;
    if (rsp_now) begin
      r = pend.pop_front();
      if (!r.stale && !redir_now) expq.push_back('{pc: r.addr, instr: r.instr});
    end
    if (redir_now) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_pc = raddr;
    end else if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      req_log.push_back(imem_req_addr);
      if (first_req < 0) first_req = cyc;
      pend.push_back('{addr: exp_pc, instr: (nop_mode ? NOP : 32'($urandom)),
                       due: cyc + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_instr = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    idle_inputs();
    pend.delete();
    expq.delete();
    req_log.delete();
    exp_pc = RESET_PC;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    first_req = -1;
    first_ov  = -1;
    max_cnt   = 0;
    deq_cnt   = 0;
  endtask

  task automatic wait_first_output(input string name, input logic [63:0] pc);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        chk(name, out_pc, pc);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, no out_valid, expected pc %h", name, pc);
    end
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Streaming with 1-cycle memory.
    lat_min = 1; lat_max = 1; rdy_pct = 100; reqrdy_pct = 100; redir_pct = 0; nop_mode = 1'b1;
    repeat (30) step();
`ifdef FQ_BYPASS_EN
    chk("fill_latency", 64'(first_ov - first_req), 64'd1);
`else
    chk("fill_latency", 64'(first_ov - first_req), 64'd2);
`endif
    chk("stream_count_le1", 64'(max_cnt <= 1), 64'd1);
    chk("stream_throughput", 64'(deq_cnt >= 26), 64'd1);

    // Decode stall fills the queue to DEPTH and stops fetch.
    do_reset();
    rdy_pct = 0;
    repeat (10) step();
    chk("stall_count", 64'(count), 64'(DEPTH));
    chk("stall_req_valid", 64'(imem_req_valid), 64'h0);
    chk("stall_head_pc", out_pc, RESET_PC);
    rdy_pct = 100;
    repeat (10) step();
    chk("stall_5th_req", (req_log.size() > 4) ? req_log[4] : 64'hx, 64'h10);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step();
    chk("redir_outstanding", 64'(pend.size()), 64'd2);
    force_redir = 1'b1; force_addr = 64'h100;
    step();
    force_redir = 1'b0;
    wait_first_output("redir_first_pc", 64'h100);

    // Redirect coinciding with a response and a dequeue.
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    force_redir = 1'b1; force_addr = 64'h2000;
    step();
    force_redir = 1'b0;
    chk("redir_collide_setup", 64'(imem_rsp_valid && out_valid && out_ready), 64'd1);
    wait_first_output("redir_collide_pc", 64'h2000);

    // Asynchronous reset with entries queued and a request in flight.
    do_reset();
    lat_min = 4; lat_max = 4; rdy_pct = 0;
    for (int i = 0; i < 30 && !(expq.size() == 3 && pend.size() >= 1); i++) step();
    chk("midreset_setup", 64'(expq.size() == 3 && pend.size() >= 1), 64'd1);
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    orphan = 1'b1;
    step();
    orphan = 1'b0;
    step();
    chk("orphan_rsp_err", 64'(rsp_err), 64'd1);
    repeat (5) step();
    chk("restart_pc", (req_log.size() > 0) ? req_log[0] : 64'hx, RESET_PC);
    chk("rsp_err_sticky", 64'(rsp_err), 64'(err_exp));

    // Fetch address wrap-around.
    do_reset();
    repeat (3) step();
    force_redir = 1'b1; force_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    force_redir = 1'b0;
    req_log.delete();
    repeat (6) step();
    chk("wrap_req_count", 64'(req_log.size() >= 3), 64'd1);
    if (req_log.size() >= 3) begin
      chk("wrap_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_req1", req_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_req2", req_log[2], 64'h0);
    end

    // Randomized traffic: variable latency, stalls, back-pressure and redirects.
    do_reset();
    nop_mode = 1'b0;
    lat_min = 1; lat_max = 5; rdy_pct = 60; reqrdy_pct = 70; redir_pct = 3;
    repeat (2000) step();
    lat_min = 1; lat_max = 2; rdy_pct = 90; reqrdy_pct = 90; redir_pct = 8;
    repeat (1500) step();
    redir_pct = 0; rdy_pct = 100;
    repeat (20) step();
    chk("final_rsp_err", 64'(rsp_err), 64'(err_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end feeding the IF/ID pipeline register.
- Generates sequential fetch addresses (PC+4) and issues them to instruction memory, which answers in order with variable latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- On a branch redirect it flushes the FIFO and discards every response still in flight.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTST, 2, maximum outstanding imem requests (1..DEPTH)
RESET_PC, 64'h0, fetch address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  64  fetch address
imem_rsp_valid  input  1  instruction returned (in order)
imem_rsp_instr  input  32  returned instruction
redirect_valid  input  1  branch taken; restart fetch
redirect_pc  input  64  new fetch address
out_valid  output  1  entry available to decode
out_ready  input  1  decode accepts (low = stall)
out_instr  output  32  head instruction
out_pc  output  64  PC of head instruction
count  output  $clog2(DEPTH)+1  current FIFO occupancy
rsp_err  output  1  sticky: response arrived with nothing outstanding

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; count=0; outstanding=0; drop_cnt=0; rsp_err=0.
  - out_valid=0, imem_req_valid=0; out_instr/out_pc read 0.
- Live credit: live = outstanding - drop_cnt.
- Request issue:
  - imem_req_valid = !redirect_valid && outstanding<MAX_OUTST && (count+live)<DEPTH.
  - imem_req_addr = fetch_pc.
  - Handshake = valid&&ready: outstanding+1, fetch_pc+=4 (64-bit wrap, 64'hFFFF_FFFF_FFFF_FFFC -> 0).
- Response handling:
  - A response with drop_cnt>0 decrements drop_cnt and outstanding; nothing is written.
  - Otherwise the response decrements outstanding and pushes {instr, pc} into the FIFO. The pc comes from a shadow queue of issued addresses, depth MAX_OUTST.
  - A response with outstanding==0 is ignored and sets rsp_err.
- FIFO:
  - Circular buffer with wrapping rd/wr pointers. Credit accounting guarantees no push when full.
  - Dequeue = out_valid && out_ready. Simultaneous push and pop keeps count unchanged.
  - out_valid = count!=0 (registered head; no combinational path from imem_rsp to out_* unless FQ_BYPASS_EN is defined).
- Redirect (redirect_valid=1 at edge) has priority over everything:
  - FIFO cleared: count=0, pointers reset.
  - fetch_pc=redirect_pc; no request is issued that cycle.
  - drop_cnt = outstanding minus 1 if a response arrives this same cycle. That response is itself discarded.
  - Any dequeue in the redirect cycle is ignored; decode must not consume out_* when redirect_valid is high.
  - Back-to-back redirects: the last one wins; drop accounting is cumulative and correct.
- Latency, empty queue, 1-cycle memory:
  - Request at edge N, response at N+1, out_valid at N+2.
  - Steady state sustains 1 instr/cycle when MAX_OUTST>=2.
- Stall: out_ready=0 holds the head stable. Requests continue until count+live==DEPTH, then imem_req_valid drops.
- rsp_err clears only on reset.

Optional Feature:
- Macro: FQ_BYPASS_EN.
- With the macro defined: when count==0 and a non-dropped response arrives, out_valid=1 and out_instr/out_pc are driven combinationally from the response that cycle.
  - If out_ready=1, the entry is consumed and not written to the FIFO.
  - If out_ready=0, it is written normally.
  - Empty-queue latency becomes request N, out_valid at N+1.
  - A redirect in the same cycle suppresses the bypass (out_valid=0).
- Without the macro: out_* always come from FIFO registers, as specified above.

Test Plan:
1. Reset release, 1-cycle memory returning 32'hD503201F (NOP), out_ready=1 -> addresses 0,4,8,... issued; out_pc sequence 0,4,8 with one entry per cycle after the 2-cycle fill; count never exceeds 1.
2. out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered (count=4), imem_req_valid=0 afterwards. Release: PCs 0,4,8,C emerge in order, then 10.
3. Memory latency 3, MAX_OUTST=2, redirect_pc=64'h100 asserted with 2 requests outstanding -> both responses dropped, count=0, next out_pc=64'h100, no stale instruction visible.
4. Redirect in the same cycle as a response and as a dequeue -> response discarded, dequeue ignored, drop_cnt equals remaining outstanding, first valid output PC = redirect_pc.
5. rst pulsed low mid-stream with 3 entries queued and 1 outstanding -> all outputs at reset values immediately (async). After release, fetch restarts at RESET_PC; the late response is ignored and sets rsp_err=1.
6. Redirect to 64'hFFFF_FFFF_FFFF_FFF8 -> PCs FFF8, FFFC, 0000 issued in sequence (wrap-around). With FQ_BYPASS_EN defined, rerun scenario 1: out_valid appears 1 cycle after the first request.
